// File: rtl/id_ctrl_stage_pkg.sv
// id_ctrl_stage_pkg: opcodes, funct3 values, ALU codes, FSM states and control-flag bundle for the decode stage
package id_ctrl_stage_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;
  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_EQ = 5'd10, ALU_GE = 5'd11,
    ALU_GEU = 5'd12, ALU_BUF = 5'd13,
    ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23,
    ALU_INV = 5'd31
  } alu_e;
  typedef enum logic [1:0] {S_EMPTY, S_HALF, S_FULL} state_e;
  typedef struct packed {
    logic reg_we;
    logic mem_rd;
    logic mem_wr;
    logic branch;
    logic jump;
    logic use_imm;
    logic use_pc;
    logic illegal;
  } ctrl_t;
  function automatic alu_e alu_of_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_ctrl_stage_if.sv
// id_ctrl_stage_if: fetch-side and execute-side handshake plus decoded bundle of the decode stage
interface id_ctrl_stage_if #(parameter int XLEN = 32, parameter int ENABLE_M = 0);
  localparam int CTRL_W = 4 + ENABLE_M;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_instr;
  logic [XLEN-1:0]   i_pc;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_pc;
  logic [CTRL_W-1:0] o_alu_ctrl;
  logic [XLEN-1:0]   o_imm;
  logic [4:0]        o_rs1, o_rs2, o_rd;
  logic [2:0]        o_funct3;
  logic              o_reg_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_use_imm, o_use_pc, o_illegal;
  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_pc, o_alu_ctrl, o_imm, o_rs1, o_rs2, o_rd, o_funct3,
           o_reg_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_use_imm, o_use_pc, o_illegal
  );
  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_pc, o_alu_ctrl, o_imm, o_rs1, o_rs2, o_rd, o_funct3,
           o_reg_we, o_mem_rd, o_mem_wr, o_branch, o_jump, o_use_imm, o_use_pc, o_illegal
  );
endinterface

// File: rtl/id_ctrl_stage_instr_decode.sv
// instr_decode: combinational map from a 32-bit instruction to ALU code, immediate, register fields and control flags
module instr_decode
  import id_ctrl_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  localparam int CTRL_W  = 4 + ENABLE_M
) (
  input  logic [31:0]       i_instr,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic [XLEN-1:0]   o_imm,
  output logic [4:0]        o_rs1,
  output logic [4:0]        o_rs2,
  output logic [4:0]        o_rd,
  output logic [2:0]        o_funct3,
  output ctrl_t             o_ctrl
);
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic        w_b30, w_ill, w_writes;
  logic [31:0] w_imm32;
  alu_e        w_alu;
  assign w_op  = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_b30 = i_instr[30];
  always_comb begin
    w_alu = ALU_INV;
    case (w_op)
      OP_R: w_alu = (w_f7 == F7_BASE) ? alu_of_f3(w_f3, 1'b0) :
                    (w_f7 == F7_ALT && (w_f3 == F3_ADD || w_f3 == F3_SR)) ? alu_of_f3(w_f3, 1'b1) :
                    (w_f7 == F7_M && ENABLE_M != 0) ? alu_e'({2'b10, w_f3}) : ALU_INV;
      // bit30 is immediate data for I-ALU except in the shift encodings
      OP_I: w_alu = (w_f3 == F3_SLL && w_b30) ? ALU_INV : alu_of_f3(w_f3, w_f3 == F3_SR && w_b30);
      OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC: w_alu = ALU_ADD;
      OP_JAL, OP_LUI: w_alu = ALU_BUF;
      OP_BR: w_alu = (w_f3[2:1] == 2'b00) ? ALU_EQ :
                     (w_f3[2:1] == 2'b10) ? ALU_GE :
                     (w_f3[2:1] == 2'b11) ? ALU_GEU : ALU_INV;
      default: w_alu = ALU_INV;
    endcase
  end
  assign w_ill = (w_alu == ALU_INV);
  assign w_imm32 =
    (w_op == OP_I || w_op == OP_LOAD || w_op == OP_JALR) ? {{20{i_instr[31]}}, i_instr[31:20]} :
    (w_op == OP_STORE) ? {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]} :
    (w_op == OP_BR) ? {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
    (w_op == OP_LUI || w_op == OP_AUIPC) ? {i_instr[31:12], 12'b0} :
    (w_op == OP_JAL) ? {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} : '0;
  assign w_writes = w_op == OP_R || w_op == OP_I || w_op == OP_LOAD || w_op == OP_JAL ||
                    w_op == OP_JALR || w_op == OP_LUI || w_op == OP_AUIPC;
  assign o_alu_ctrl = w_alu[CTRL_W-1:0];
  assign o_imm      = XLEN'($signed(w_imm32));
  assign o_rs1      = i_instr[19:15];
  assign o_rs2      = i_instr[24:20];
  assign o_rd       = i_instr[11:7];
  assign o_funct3   = w_f3;
  assign o_ctrl.reg_we  = w_writes && o_rd != 5'd0 && !w_ill;
  assign o_ctrl.mem_rd  = w_op == OP_LOAD && !w_ill;
  assign o_ctrl.mem_wr  = w_op == OP_STORE && !w_ill;
  assign o_ctrl.branch  = w_op == OP_BR && !w_ill;
  assign o_ctrl.jump    = (w_op == OP_JAL || w_op == OP_JALR) && !w_ill;
  assign o_ctrl.use_imm = !(w_op == OP_R || w_op == OP_BR);
  assign o_ctrl.use_pc  = w_op == OP_AUIPC || w_op == OP_JAL;
  assign o_ctrl.illegal = w_ill;
endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered decode stage with a 2-entry skid buffer so o_ready never depends combinationally on i_ready
module id_ctrl_stage
  import id_ctrl_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input logic          clk,
  input logic          rst,
  id_ctrl_stage_if.slave bus
);
  localparam int CTRL_W = 4 + ENABLE_M;
  localparam int BW     = 2 * XLEN + CTRL_W + 15 + 3 + $bits(ctrl_t);
  logic [CTRL_W-1:0] w_alu;
  logic [XLEN-1:0]   w_imm;
  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic [2:0]        w_f3;
  ctrl_t             w_ctrl;
  logic [BW-1:0]     w_in, r_main, r_skid;
  state_e            r_state, w_next;
  logic              r_valid, r_ready;
  logic              w_acc, w_pop, w_ld_main, w_ld_skid, w_from_skid;
  instr_decode #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_dec (
    .i_instr(bus.i_instr), .o_alu_ctrl(w_alu), .o_imm(w_imm),
    .o_rs1(w_rs1), .o_rs2(w_rs2), .o_rd(w_rd), .o_funct3(w_f3), .o_ctrl(w_ctrl)
  );
  assign w_in  = {bus.i_pc, w_alu, w_imm, w_rs1, w_rs2, w_rd, w_f3, w_ctrl};
  assign w_acc = bus.i_valid && r_ready && !bus.i_flush;
  assign w_pop = r_valid && bus.i_ready;
  always_comb begin
    w_next      = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_from_skid = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_next    = w_acc ? S_HALF : S_EMPTY;
        w_ld_main = w_acc;
      end
      S_HALF: begin
        w_next    = w_acc ? (w_pop ? S_HALF : S_FULL) : (w_pop ? S_EMPTY : S_HALF);
        w_ld_main = w_acc && w_pop;
        w_ld_skid = w_acc && !w_pop;
      end
      S_FULL: begin
        w_next      = w_pop ? S_HALF : S_FULL;
        w_ld_main   = w_pop;
        w_from_skid = 1'b1;
      end
      default: w_next = S_EMPTY;
    endcase
    if (bus.i_flush) w_next = S_EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_valid <= w_next != S_EMPTY;
      r_ready <= w_next != S_FULL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main) r_main <= w_from_skid ? r_skid : w_in;
      if (w_ld_skid) r_skid <= w_in;
    end
  end
  assign bus.o_valid = r_valid;
  assign bus.o_ready = r_ready;
  assign {bus.o_pc, bus.o_alu_ctrl, bus.o_imm, bus.o_rs1, bus.o_rs2, bus.o_rd, bus.o_funct3,
          bus.o_reg_we, bus.o_mem_rd, bus.o_mem_wr, bus.o_branch, bus.o_jump,
          bus.o_use_imm, bus.o_use_pc, bus.o_illegal} = r_main;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: scoreboard bench driving a 32-bit/no-M and a 64-bit/M instance with identical handshake traffic
module tb_id_ctrl_stage;
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  alu;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [7:0]  fl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r_rdy = 1'b0, r_fl = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0, fails = 0;
  exp_t q[2][$];
  exp_t got0, got1;
  id_ctrl_stage_if #(.XLEN(32), .ENABLE_M(0)) b0 ();
  id_ctrl_stage_if #(.XLEN(64), .ENABLE_M(1)) b1 ();
  id_ctrl_stage #(.XLEN(32), .ENABLE_M(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  id_ctrl_stage #(.XLEN(64), .ENABLE_M(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  assign got0 = '{pc: 64'(b0.o_pc), alu: 5'(b0.o_alu_ctrl), imm: 64'(b0.o_imm), rs1: b0.o_rs1,
                  rs2: b0.o_rs2, rd: b0.o_rd, f3: b0.o_funct3,
                  fl: {b0.o_reg_we, b0.o_mem_rd, b0.o_mem_wr, b0.o_branch, b0.o_jump,
                       b0.o_use_imm, b0.o_use_pc, b0.o_illegal}};
  assign got1 = '{pc: b1.o_pc, alu: b1.o_alu_ctrl, imm: b1.o_imm, rs1: b1.o_rs1,
                  rs2: b1.o_rs2, rd: b1.o_rd, f3: b1.o_funct3,
                  fl: {b1.o_reg_we, b1.o_mem_rd, b1.o_mem_wr, b1.o_branch, b1.o_jump,
                       b1.o_use_imm, b1.o_use_pc, b1.o_illegal}};

  // Reference decode straight from the ISA tables; ALU code 31 stands for INVALID
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit m);
    exp_t e;
    logic [4:0] rt [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    logic [6:0] op = ins[6:0];
    logic [6:0] f7 = ins[31:25];
    logic [2:0] f3 = ins[14:12];
    int alu = -1;
    longint imm = 0;
    longint i_imm = longint'($signed(ins[31:20]));
    longint u_imm = longint'($signed({ins[31:12], 12'h000}));
    bit ill, wr;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) alu = int'(rt[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
        else if (f7 == 7'h01 && m) alu = 16 + int'(f3);
      end
      7'h13: begin
        imm = i_imm;
        if (f3 == 3'd5) alu = ins[30] ? 7 : 6;
        else if (!(f3 == 3'd1 && ins[30])) alu = int'(rt[f3]);
      end
      7'h03, 7'h67: begin alu = 0; imm = i_imm; end
      7'h23: begin alu = 0; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h17: begin alu = 0; imm = u_imm; end
      7'h37: begin alu = 13; imm = u_imm; end
      7'h6F: begin alu = 13; imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h63: begin
        imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        alu = (f3 < 3'd2) ? 10 : (f3 == 3'd4 || f3 == 3'd5) ? 11 : (f3 >= 3'd6) ? 12 : -1;
      end
      default: ;
    endcase
    ill = alu < 0;
    wr = op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
    e.pc  = pc;
    e.alu = ill ? 5'h1F : 5'(alu);
    e.imm = imm;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    e.fl  = {wr && ins[11:7] != 5'd0 && !ill, op == 7'h03 && !ill, op == 7'h23 && !ill,
             op == 7'h63 && !ill, (op == 7'h6F || op == 7'h67) && !ill,
             !(op == 7'h33 || op == 7'h63), op == 7'h17 || op == 7'h6F, ill};
    return e;
  endfunction

  function automatic exp_t narrow(input exp_t e);
    exp_t n = e;
    n.pc[63:32]  = '0;
    n.imm[63:32] = '0;
    n.alu[4]     = 1'b0;
    return n;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
    logic [31:0] r = $urandom;
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    if ($urandom_range(0, 15) == 0) return r;
    return {f7, r[24:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    logic [63:0] pc;
    logic a0, a1;
    @(negedge clk);
    pc = {$urandom, $urandom};
    r_rdy = rdy;
    r_fl  = fl;
    b0.i_valid = v; b0.i_instr = ins; b0.i_pc = pc[31:0]; b0.i_ready = rdy; b0.i_flush = fl;
    b1.i_valid = v; b1.i_instr = ins; b1.i_pc = pc;       b1.i_ready = rdy; b1.i_flush = fl;
    a0 = v && b0.o_ready;
    a1 = v && b1.o_ready;
    @(posedge clk);
    if (a0 && !fl) q[0].push_back(narrow(model(ins, pc, 1'b0)));
    if (a1 && !fl) q[1].push_back(model(ins, pc, 1'b1));
  endtask

  // Queue mirrors what each stage holds: front is the presented bundle, size gives valid/ready
  always @(negedge clk) begin
    if (mon_en) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        exp_t g;
        logic vld, rdy;
        g   = d ? got1 : got0;
        vld = d ? b1.o_valid : b0.o_valid;
        rdy = d ? b1.o_ready : b0.o_ready;
        checks++;
        if (vld !== (q[d].size() > 0)) begin
          fails++;
          $display("FAIL d%0d o_valid got=%0b exp=%0b", d, vld, q[d].size() > 0);
        end
        checks++;
        if (rdy !== (q[d].size() < 2)) begin
          fails++;
          $display("FAIL d%0d o_ready got=%0b exp=%0b", d, rdy, q[d].size() < 2);
        end
        if (vld === 1'b1 && q[d].size() > 0) begin
          checks++;
          if (g !== q[d][0]) begin
            fails++;
            $display("FAIL d%0d bundle got=%h exp=%h", d, g, q[d][0]);
          end
          if (r_rdy) void'(q[d].pop_front());
        end
        if (r_fl) q[d].delete();
      end
    end
  end

  initial begin
    logic [31:0] dir [5] = '{32'h40208033, 32'hFFF00093, 32'h02208033, 32'h0020A063, 32'h0000007F};
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (b0.o_valid !== 1'b0 || b0.o_ready !== 1'b1 || b1.o_valid !== 1'b0 || b1.o_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake got=%b%b%b%b exp=0101", b0.o_valid, b0.o_ready, b1.o_valid, b1.o_ready);
    end
    checks++;
    if (got0 !== '0 || got1 !== '0) begin
      fails++;
      $display("FAIL reset_bundle got0=%h got1=%h exp=0", got0, got1);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    foreach (dir[i]) step(1'b1, dir[i], 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00500113, 1'b0, 1'b0);
    step(1'b1, 32'h00A00193, 1'b0, 1'b0);
    repeat (2) step(1'b1, 32'h00F00213, 1'b0, 1'b0);
    repeat (2) step(1'b1, 32'h00F00213, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00108093, 1'b0, 1'b0);
    step(1'b1, 32'h00210113, 1'b0, 1'b0);
    step(1'b1, 32'h00318193, 1'b0, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d/%0d exp=0/0", q[0].size(), q[1].size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
